// File: rtl/sr_cmd_pkg.sv
// Shared types and widths for the SR command generator.
//   state_t  : command FSM state (IDLE / ISSUE / HOLD), fixed binary encoding
//   DB_CNT_W : debounce counter width (covers DB_CYCLES up to 255)
//   HO_CNT_W : holdoff counter width (covers HOLDOFF up to 15)
package sr_cmd_pkg;

    localparam int unsigned DB_CNT_W = 8;
    localparam int unsigned HO_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        HOLD  = 2'b10
    } state_t;

endpackage

// File: rtl/sr_debounce.sv
// One input channel: 2-flop synchronizer, debounce counter and rising-edge detect.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   raw  : asynchronous, bouncy level input
//   rise : one-cycle pulse when the debounced level goes 0 -> 1
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    logic                sync1_q, sync2_q;
    logic                db_q, db_d;
    logic                db_prev_q;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == DB_CNT_W'(DB_CYCLES - 1)) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign rise = db_q & ~db_prev_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns two bouncy push-button levels into clean one-cycle S/R commands for a
// downstream SR flip-flop, with a holdoff gap after every command.
//   clk, rst    : clock (rising edge) and synchronous active-high reset
//   set_req_raw : asynchronous set request level
//   clr_req_raw : asynchronous clear request level
//   S, R        : registered one-cycle set / reset commands (never both high)
//   busy        : high while a command is being issued or held off
//   conflict    : registered one-cycle pulse when set and clear collide
//   q_shadow    : expected downstream Q after the last issued command
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 8,
    parameter int unsigned HOLDOFF   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req_raw,
    input  logic clr_req_raw,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic q_shadow
);

    logic set_ev, clr_ev;

    sr_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_set (
        .clk  (clk),
        .rst  (rst),
        .raw  (set_req_raw),
        .rise (set_ev)
    );

    sr_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_clr (
        .clk  (clk),
        .rst  (rst),
        .raw  (clr_req_raw),
        .rise (clr_ev)
    );

    state_t              state_q, state_d;
    logic [HO_CNT_W-1:0] ho_q, ho_d;
    logic                pend_set_q, pend_set_d;
    logic                pend_clr_q, pend_clr_d;
    logic                s_q, s_d;
    logic                r_q, r_d;
    logic                conflict_q, conflict_d;
    logic                q_shadow_q, q_shadow_d;
    logic                eff_set, eff_clr;

    assign eff_set = set_ev | pend_set_q;
    assign eff_clr = clr_ev | pend_clr_q;

    always_comb begin
        state_d    = state_q;
        ho_d       = ho_q;
        pend_set_d = pend_set_q;
        pend_clr_d = pend_clr_q;
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        q_shadow_d = q_shadow_q;

        case (state_q)
            IDLE: begin
                if (eff_set && eff_clr) begin
                    // Colliding requests cancel each other; nothing is issued.
                    conflict_d = 1'b1;
                    pend_set_d = 1'b0;
                    pend_clr_d = 1'b0;
                end else if (eff_set) begin
                    state_d    = ISSUE;
                    s_d        = 1'b1;
                    q_shadow_d = 1'b1;
                    pend_set_d = 1'b0;
                end else if (eff_clr) begin
                    state_d    = ISSUE;
                    r_d        = 1'b1;
                    q_shadow_d = 1'b0;
                    pend_clr_d = 1'b0;
                end
            end
            ISSUE: begin
                state_d    = HOLD;
                ho_d       = HO_CNT_W'(HOLDOFF - 1);
                pend_set_d = pend_set_q | set_ev;
                pend_clr_d = pend_clr_q | clr_ev;
            end
            HOLD: begin
                pend_set_d = pend_set_q | set_ev;
                pend_clr_d = pend_clr_q | clr_ev;
                if (ho_q == '0) begin
                    state_d = IDLE;
                end else begin
                    ho_d = ho_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ho_q       <= '0;
            pend_set_q <= 1'b0;
            pend_clr_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            q_shadow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ho_q       <= ho_d;
            pend_set_q <= pend_set_d;
            pend_clr_q <= pend_clr_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
            q_shadow_q <= q_shadow_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign conflict = conflict_q;
    assign q_shadow = q_shadow_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen (DB_CYCLES=4, HOLDOFF=2): directed scenarios
// followed by random bouncy stimulus, all checked cycle by cycle against a
// behavioural model built from edge counts, a sample delay queue and a
// "free from edge N" scheduler.
module tb_sr_cmd_gen;

    localparam int DB = 4;
    localparam int HO = 2;

    logic clk = 1'b0;
    logic rst, set_raw, clr_raw;
    logic S, R, busy, conflict, q_shadow;

    always #5 clk = ~clk;

    sr_cmd_gen #(
        .DB_CYCLES (DB),
        .HOLDOFF   (HO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .set_req_raw (set_raw),
        .clr_req_raw (clr_raw),
        .S           (S),
        .R           (R),
        .busy        (busy),
        .conflict    (conflict),
        .q_shadow    (q_shadow)
    );

    int total  = 0;
    int passed = 0;
    int n      = 0;

    // Behavioural model state
    logic raw_s[$];
    logic raw_c[$];
    int   run_s, run_c;
    logic lvl_s, lvl_c, lvld_s, lvld_c;
    logic pend_s, pend_c;
    int   free_at;
    logic e_S, e_R, e_conf, e_q, e_busy;

    // Observation bookkeeping
    int last_pulse;
    int s_edge, r_edge, s_cnt, r_cnt, conf_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, n, obs, exp);
    endtask

    // Advance the model by one clock edge given the inputs sampled at that edge.
    task automatic model_edge(input logic r, input logic a_s, input logic a_c);
        logic ev_s, ev_c, sy_s, sy_c;
        e_S = 1'b0; e_R = 1'b0; e_conf = 1'b0;
        if (r) begin
            raw_s.delete(); raw_c.delete();
            run_s = 0; run_c = 0;
            lvl_s = 0; lvl_c = 0; lvld_s = 0; lvld_c = 0;
            pend_s = 0; pend_c = 0;
            free_at = 0; e_q = 0; e_busy = 0;
            return;
        end
        // Events visible before this edge
        ev_s = lvl_s & ~lvld_s;
        ev_c = lvl_c & ~lvld_c;
        // Synchronized value = raw as sampled two edges earlier
        raw_s.push_back(a_s);
        raw_c.push_back(a_c);
        if (raw_s.size() > 3) void'(raw_s.pop_front());
        if (raw_c.size() > 3) void'(raw_c.pop_front());
        sy_s = (raw_s.size() == 3) ? raw_s[0] : 1'b0;
        sy_c = (raw_c.size() == 3) ? raw_c[0] : 1'b0;
        lvld_s = lvl_s;
        lvld_c = lvl_c;
        if (sy_s != lvl_s) begin
            run_s++;
            if (run_s == DB) begin lvl_s = ~lvl_s; run_s = 0; end
        end else run_s = 0;
        if (sy_c != lvl_c) begin
            run_c++;
            if (run_c == DB) begin lvl_c = ~lvl_c; run_c = 0; end
        end else run_c = 0;
        // Scheduler: idle decisions are taken only from edge free_at onwards
        if (n >= free_at) begin
            if ((ev_s | pend_s) && (ev_c | pend_c)) begin
                e_conf = 1'b1; pend_s = 0; pend_c = 0;
            end else if (ev_s | pend_s) begin
                e_S = 1'b1; e_q = 1'b1; pend_s = 0; free_at = n + HO + 2;
            end else if (ev_c | pend_c) begin
                e_R = 1'b1; e_q = 1'b0; pend_c = 0; free_at = n + HO + 2;
            end
        end else begin
            pend_s = pend_s | ev_s;
            pend_c = pend_c | ev_c;
        end
        e_busy = (n < free_at - 1);
    endtask

    task automatic step(input logic r, input logic a_s, input logic a_c);
        rst = r; set_raw = a_s; clr_raw = a_c;
        @(posedge clk);
        n++;
        model_edge(r, a_s, a_c);
        #1;
        chk("S", int'(S), int'(e_S));
        chk("R", int'(R), int'(e_R));
        chk("conflict", int'(conflict), int'(e_conf));
        chk("q_shadow", int'(q_shadow), int'(e_q));
        chk("busy", int'(busy), int'(e_busy));
        if (r) last_pulse = -1000;
        if (S === 1'b1 && R === 1'b1) chk("S_and_R", 1, 0);
        if (S === 1'b1 || R === 1'b1) begin
            chk("pulse_gap", int'((n - last_pulse) >= HO + 1), 1);
            last_pulse = n;
        end
        if (S === 1'b1) begin s_edge = n; s_cnt++; end
        if (R === 1'b1) begin r_edge = n; r_cnt++; end
        if (conflict === 1'b1) conf_cnt++;
    endtask

    task automatic clr_obs();
        s_edge = -1; r_edge = -1; s_cnt = 0; r_cnt = 0; conf_cnt = 0;
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int t0, q_before;
        int left_s, left_c;
        logic v_s, v_c;
        last_pulse = -1000;
        clr_obs();

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        idle_steps(4);

        // Stable set request: fixed latency, one pulse, busy for HOLDOFF+1 cycles
        clr_obs();
        t0 = n + 1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        chk("set_latency", s_edge - t0, DB + 2);
        chk("set_count", s_cnt, 1);
        idle_steps(15);

        // Bouncy set: 1-0-1-0 then stable
        clr_obs();
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
        t0 = n + 1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        chk("bounce_count", s_cnt, 1);
        chk("bounce_latency", s_edge - t0, DB + 2);
        idle_steps(15);

        // Simultaneous requests collide
        clr_obs();
        q_before = int'(q_shadow);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1);
        chk("conflict_count", conf_cnt, 1);
        chk("conflict_no_cmd", s_cnt + r_cnt, 0);
        chk("conflict_q_kept", int'(q_shadow), q_before);
        idle_steps(15);

        // Clear arriving during HOLD after a set is serviced right after HOLD
        clr_obs();
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
        chk("pend_r_count", r_cnt, 1);
        chk("pend_r_gap", r_edge - s_edge, HO + 2);
        chk("pend_q_final", int'(q_shadow), 0);
        idle_steps(15);

        // Reset during HOLD with a clear pending drops the clear
        clr_obs();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40 && s_cnt == 0; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("rst_S", int'(S), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_q", int'(q_shadow), 0);
        r_cnt = 0;
        idle_steps(20);
        chk("rst_no_R", r_cnt, 0);

        // Request held through reset release
        clr_obs();
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        t0 = n + 1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        chk("post_rst_latency", s_edge - t0, DB + 2);
        chk("post_rst_count", s_cnt, 1);
        idle_steps(15);

        // Random bouncy stimulus
        left_s = 0; left_c = 0; v_s = 0; v_c = 0;
        for (int i = 0; i < 10000; i++) begin
            if (left_s == 0) begin
                v_s = 1'($urandom_range(0, 1)); left_s = $urandom_range(1, 12);
            end
            if (left_c == 0) begin
                v_c = 1'($urandom_range(0, 1)); left_c = $urandom_range(1, 12);
            end
            left_s--; left_c--;
            step(($urandom_range(0, 1999) == 0), v_s, v_c);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 8: consecutive stable synchronized cycles required to accept a level change (range 1..255).
REQ-002 SHALL have parameter HOLDOFF, default 2: idle cycles enforced after every issued command (range 1..15).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port set_req_raw  input  1  asynchronous, bouncy set request (push-button level).
REQ-006 SHALL have port clr_req_raw  input  1  asynchronous, bouncy clear request.
REQ-007 SHALL have port S  output  1  registered one-cycle set command to the downstream SR flip-flop.
REQ-008 SHALL have port R  output  1  registered one-cycle reset command to the downstream SR flip-flop.
REQ-009 SHALL have port busy  output  1  high while in ISSUE or HOLD.
REQ-010 SHALL have port conflict  output  1  registered one-cycle pulse when set and clear are dropped together.
REQ-011 SHALL have port q_shadow  output  1  expected downstream Q: 1 after an S issue, 0 after an R issue.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce SHALL keep a per-channel level db and counter; counter increments each cycle sync!=db, clears each cycle sync==db; db toggles and counter clears when counter reaches DB_CYCLES.
REQ-014 An event SHALL be a db rising edge (db=1, previous db=0); falling edges are ignored.
REQ-015 Latency: raw held stable high from edge k SHALL yield S (or R) high during the cycle after edge k+DB_CYCLES+2.
REQ-016 FSM states SHALL be IDLE, ISSUE, HOLD.
REQ-017 IDLE: effective request = event OR pending flag, per channel; set only -> ISSUE with S=1, q_shadow<=1; clear only -> ISSUE with R=1, q_shadow<=0; both -> conflict=1 one cycle, both pending cleared, remain IDLE, no command.
REQ-018 ISSUE SHALL last exactly one cycle (S or R high), then HOLD with a HOLDOFF-cycle down-counter.
REQ-019 HOLD SHALL return to IDLE when the counter expires; busy=0 in IDLE.
REQ-020 An event arriving in ISSUE or HOLD SHALL set that channel's pending flag; repeated events saturate (one pending per channel).
REQ-021 S and R SHALL never be high in the same cycle; 2'b11 is never produced.
REQ-022 Pending flags SHALL be consumed (cleared) when serviced in IDLE.

Reset
REQ-023 On rst, S, R, busy, conflict, q_shadow SHALL be 0 at the next edge; synchronizers, db levels, counters and pending flags 0; state IDLE.
REQ-024 Reset mid-ISSUE or mid-HOLD SHALL abort the command and drop pending requests.
REQ-025 A raw input held high through reset release SHALL produce one event after the REQ-015 latency measured from the first post-reset edge.

Structure
REQ-026 Package sr_cmd_pkg SHALL hold the state typedef (IDLE/ISSUE/HOLD) and its encoding.
REQ-027 Sub-module sr_debounce (synchronizer, debounce counter, rising-edge detect, DB_CYCLES parameter) SHALL be instantiated once per channel.
REQ-028 The FSM, pending flags, holdoff counter and outputs SHALL reside in sr_cmd_gen.

Verification (DB_CYCLES=4, HOLDOFF=2)
REQ-029 set_req_raw high from edge 10, held -> S=1 for exactly the cycle after edge 16, q_shadow=1 from edge 16, busy high for 3 cycles.
REQ-030 set_req_raw bounces 1-0-1-0 on one-cycle spacing, then stable high -> exactly one S pulse, timed from the start of the stable period.
REQ-031 Both raw inputs rise on the same edge -> conflict pulse one cycle, S=R=0 throughout, q_shadow unchanged.
REQ-032 clear event arrives during HOLD after a set -> R pulse issued on the first IDLE cycle after HOLD, q_shadow 1->0.
REQ-033 rst asserted during HOLD with clear pending -> all outputs 0 next edge, no R pulse afterwards with clr_req_raw low.
REQ-034 Random raw stimulus 10k cycles -> S&R never both 1; each pulse exactly one cycle; pulses separated by at least HOLDOFF+1 cycles.
